// File: rtl/oob_dev.sv
// oob_dev - device-side SATA OOB responder.
// Answers host COMRESET with COMINIT and host COMWAKE with COMWAKE, then runs
// the ALIGNp/SYNCp speed handshake and declares the link up. It muxes OOB
// primitives onto the tx stream and passes rx data straight through.
// Ports:
//   clk, rst                     usrclk2, synchronous active-high reset
//   gtx_ready                    all GTX resets done
//   rxcominitdet_in/rxcomwakedet_in/rxelecidle_in/txcomfinish_in  GTX OOB status
//   txcominit/txcomwake          one-cycle OOB burst requests
//   txelecidle                   drive tx line idle
//   txdata_in/txcharisk_in       link-layer tx word, forwarded only in LINK
//   txdata_out/txcharisk_out     registered tx word to GTX
//   rxdata_in/rxcharisk_in       rx word from GTX
//   rxdata_out/rxcharisk_out     combinational rx bypass
//   rxbyteisaligned              GTX comma alignment (async, resynced)
//   phy_ready                    LINK & gtx_ready & aligned
//   link_up/link_down/oob_error  one-cycle event pulses
module oob_dev #(
  parameter int unsigned DATA_BYTE_WIDTH = 4,
  parameter int unsigned CLK_SPEED_GRADE = 1,
  parameter int unsigned COMWAKE_TIMEOUT = 32768,
  parameter int unsigned ALIGN_TIMEOUT   = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         gtx_ready,
  input  logic                         rxcominitdet_in,
  input  logic                         rxcomwakedet_in,
  input  logic                         rxelecidle_in,
  input  logic                         txcomfinish_in,
  output logic                         txcominit,
  output logic                         txcomwake,
  output logic                         txelecidle,
  input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
  input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
  output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
  output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
  input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
  input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
  output logic [DATA_BYTE_WIDTH*8-1:0] rxdata_out,
  output logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_out,
  input  logic                         rxbyteisaligned,
  output logic                         phy_ready,
  output logic                         link_up,
  output logic                         link_down,
  output logic                         oob_error
);

  localparam logic [DATA_BYTE_WIDTH*8-1:0] ALIGN_P = 32'h7B4A4ABC;
  localparam logic [DATA_BYTE_WIDTH*8-1:0] SYNC_P  = 32'hB5B5957C;
  localparam logic [DATA_BYTE_WIDTH-1:0]   PRIM_K  = 4'b0001;

  // Timer holds (cycles in state - 1); a timeout fires on the cycle the
  // limit-th cycle is sampled. Limits beyond the 16-bit range clip to the
  // saturation value so the timeout can still be reached.
  localparam int unsigned CW_RAW = COMWAKE_TIMEOUT * CLK_SPEED_GRADE;
  localparam int unsigned AL_RAW = ALIGN_TIMEOUT * CLK_SPEED_GRADE;
  localparam logic [15:0] CW_LAST = 16'((CW_RAW > 65536) ? 65535 : CW_RAW - 1);
  localparam logic [15:0] AL_LAST = 16'((AL_RAW > 65536) ? 65535 : AL_RAW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_COMINIT, S_WAIT_COMWAKE, S_SEND_COMWAKE,
    S_WAIT_NOIDLE, S_SEND_ALIGN, S_SEND_SYNC, S_LINK
  } state_t;

  state_t                         state_q, state_d;
  logic [15:0]                    timer_q;
  logic [1:0]                     sync_cnt_q, sync_cnt_d;
  logic                           aligned_meta_q, aligned_q;
  logic                           oob_error_d, txelecidle_d;
  logic [DATA_BYTE_WIDTH*8-1:0]   txdata_d;
  logic [DATA_BYTE_WIDTH-1:0]     txcharisk_d;
  logic                           rx_align, rx_prim;

  assign rxdata_out    = rxdata_in;
  assign rxcharisk_out = rxcharisk_in;

  assign rx_align = (rxdata_in == ALIGN_P) && (rxcharisk_in == PRIM_K);
  assign rx_prim  = rxcharisk_in[0] && !rx_align;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      sync_cnt_q     <= '0;
      aligned_meta_q <= 1'b0;
      aligned_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_cnt_q     <= sync_cnt_d;
      aligned_meta_q <= rxbyteisaligned;
      aligned_q      <= aligned_meta_q;
      if (state_d != state_q)
        timer_q <= '0;
      else if (timer_q != '1)
        timer_q <= timer_q + 16'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    sync_cnt_d   = '0;
    oob_error_d  = 1'b0;
    txelecidle_d = 1'b1;
    txdata_d     = '0;
    txcharisk_d  = '0;

    // Detects are checked before timeouts so a detect in the timeout cycle wins.
    case (state_q)
      S_IDLE:
        if (gtx_ready && rxcominitdet_in) state_d = S_SEND_COMINIT;
      S_SEND_COMINIT:
        if (txcomfinish_in) state_d = S_WAIT_COMWAKE;
      S_WAIT_COMWAKE:
        if (rxcominitdet_in)        state_d = S_SEND_COMINIT;
        else if (rxcomwakedet_in)   state_d = S_SEND_COMWAKE;
        else if (timer_q >= CW_LAST) begin
          state_d     = S_IDLE;
          oob_error_d = 1'b1;
        end
      S_SEND_COMWAKE:
        if (txcomfinish_in) state_d = S_WAIT_NOIDLE;
      S_WAIT_NOIDLE:
        if (rxcominitdet_in)     state_d = S_SEND_COMINIT;
        else if (!rxelecidle_in) state_d = S_SEND_ALIGN;
      S_SEND_ALIGN:
        if (rxcominitdet_in)            state_d = S_SEND_COMINIT;
        else if (rx_align && aligned_q) state_d = S_SEND_SYNC;
        else if (timer_q >= AL_LAST) begin
          state_d     = S_IDLE;
          oob_error_d = 1'b1;
        end
      S_SEND_SYNC:
        if (rxcominitdet_in) state_d = S_SEND_COMINIT;
        else begin
          sync_cnt_d = rx_prim ? 2'(sync_cnt_q + 2'd1) : 2'd0;
          if (sync_cnt_d == 2'd3) state_d = S_LINK;
          else if (timer_q >= AL_LAST) begin
            state_d     = S_IDLE;
            oob_error_d = 1'b1;
          end
        end
      S_LINK:
        if (rxcominitdet_in) state_d = S_SEND_COMINIT;
      default:
        state_d = S_IDLE;
    endcase

    // Losing the GTX drops everything back to IDLE silently.
    if (state_q != S_IDLE && !gtx_ready) begin
      state_d     = S_IDLE;
      sync_cnt_d  = '0;
      oob_error_d = 1'b0;
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register.
    case (state_d)
      S_SEND_ALIGN: begin
        txelecidle_d = 1'b0;
        txdata_d     = ALIGN_P;
        txcharisk_d  = PRIM_K;
      end
      S_SEND_SYNC: begin
        txelecidle_d = 1'b0;
        txdata_d     = SYNC_P;
        txcharisk_d  = PRIM_K;
      end
      S_LINK: begin
        txelecidle_d = 1'b0;
        txdata_d     = txdata_in;
        txcharisk_d  = txcharisk_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txcominit     <= 1'b0;
      txcomwake     <= 1'b0;
      txelecidle    <= 1'b1;
      txdata_out    <= '0;
      txcharisk_out <= '0;
      phy_ready     <= 1'b0;
      link_up       <= 1'b0;
      link_down     <= 1'b0;
      oob_error     <= 1'b0;
    end else begin
      txcominit     <= (state_d == S_SEND_COMINIT) && (state_q != S_SEND_COMINIT);
      txcomwake     <= (state_d == S_SEND_COMWAKE) && (state_q != S_SEND_COMWAKE);
      txelecidle    <= txelecidle_d;
      txdata_out    <= txdata_d;
      txcharisk_out <= txcharisk_d;
      phy_ready     <= (state_d == S_LINK) && gtx_ready && aligned_q;
      link_up       <= (state_d == S_LINK) && (state_q != S_LINK);
      link_down     <= (state_q == S_LINK) && (state_d != S_LINK);
      oob_error     <= oob_error_d;
    end
  end

endmodule

// File: tb/tb_oob_dev.sv
// tb_oob_dev - directed self-checking bench for oob_dev.
// Inputs change 1 ns after the rising edge; registered outputs are checked
// at that same point, i.e. they reflect the edge just taken.
module tb_oob_dev;

  localparam logic [31:0] ALIGN_P = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_P  = 32'hB5B5957C;
  localparam logic [31:0] D102    = 32'h4A4A4A4A;

  logic        clk = 1'b0;
  logic        rst;
  logic        gtx_ready;
  logic        rxcominitdet_in, rxcomwakedet_in, rxelecidle_in, txcomfinish_in;
  logic        txcominit, txcomwake, txelecidle;
  logic [31:0] txdata_in, txdata_out, rxdata_in, rxdata_out;
  logic [3:0]  txcharisk_in, txcharisk_out, rxcharisk_in, rxcharisk_out;
  logic        rxbyteisaligned;
  logic        phy_ready, link_up, link_down, oob_error;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  oob_dev #(
    .DATA_BYTE_WIDTH(4),
    .CLK_SPEED_GRADE(1),
    .COMWAKE_TIMEOUT(32768),
    .ALIGN_TIMEOUT(4096)
  ) dut (
    .clk(clk), .rst(rst), .gtx_ready(gtx_ready),
    .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
    .rxelecidle_in(rxelecidle_in), .txcomfinish_in(txcomfinish_in),
    .txcominit(txcominit), .txcomwake(txcomwake), .txelecidle(txelecidle),
    .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
    .txdata_out(txdata_out), .txcharisk_out(txcharisk_out),
    .rxdata_in(rxdata_in), .rxcharisk_in(rxcharisk_in),
    .rxdata_out(rxdata_out), .rxcharisk_out(rxcharisk_out),
    .rxbyteisaligned(rxbyteisaligned), .phy_ready(phy_ready),
    .link_up(link_up), .link_down(link_down), .oob_error(oob_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx_word(input logic [31:0] d, input logic [3:0] k);
    rxdata_in    = d;
    rxcharisk_in = k;
  endtask

  // From IDLE, run the host side of COMRESET/COMWAKE and return just after
  // the edge that enters SEND_ALIGN.
  task automatic go_to_align();
    rxelecidle_in = 1'b1;
    rx_word(D102, 4'b0000);
    rxcominitdet_in = 1'b1; step();
    rxcominitdet_in = 1'b0; step(3);
    txcomfinish_in  = 1'b1; step();
    txcomfinish_in  = 1'b0; step(3);
    rxcomwakedet_in = 1'b1; step();
    rxcomwakedet_in = 1'b0; step();
    txcomfinish_in  = 1'b1; step();
    txcomfinish_in  = 1'b0; step();
    rxelecidle_in   = 1'b0; step();
  endtask

  initial begin
    int early;
    logic [31:0] sync_seq [6];
    logic [3:0]  sync_k   [6];

    rst = 1'b1; gtx_ready = 1'b0;
    rxcominitdet_in = 1'b0; rxcomwakedet_in = 1'b0;
    rxelecidle_in = 1'b1; txcomfinish_in = 1'b0;
    txdata_in = '0; txcharisk_in = '0;
    rx_word(D102, 4'b0000);
    rxbyteisaligned = 1'b0;
    step(3);

    // Reset state
    chk("rst_txelecidle", {31'b0, txelecidle}, 32'd1);
    chk("rst_txcominit",  {31'b0, txcominit},  32'd0);
    chk("rst_txcomwake",  {31'b0, txcomwake},  32'd0);
    chk("rst_txdata",     txdata_out,          32'd0);
    chk("rst_txcharisk",  {28'b0, txcharisk_out}, 32'd0);
    chk("rst_flags",      {28'b0, phy_ready, link_up, link_down, oob_error}, 32'd0);

    rst = 1'b0; gtx_ready = 1'b1; rxbyteisaligned = 1'b1;
    step(2);

    // Nominal bring-up
    rxcominitdet_in = 1'b1; step();
    chk("nom_cominit_pulse", {31'b0, txcominit}, 32'd1);
    chk("nom_cominit_idle",  {31'b0, txelecidle}, 32'd1);
    rxcominitdet_in = 1'b0; step();
    chk("nom_cominit_once",  {31'b0, txcominit}, 32'd0);
    step(18);
    txcomfinish_in = 1'b1; step();
    txcomfinish_in = 1'b0; step(99);
    rxcomwakedet_in = 1'b1; step();
    chk("nom_comwake_pulse", {31'b0, txcomwake}, 32'd1);
    rxcomwakedet_in = 1'b0; step();
    chk("nom_comwake_once",  {31'b0, txcomwake}, 32'd0);
    step(18);
    txcomfinish_in = 1'b1; step();
    txcomfinish_in = 1'b0; step();
    chk("nom_noidle_idle", {31'b0, txelecidle}, 32'd1);
    rxelecidle_in = 1'b0; step();
    chk("nom_align_tx",    txdata_out, ALIGN_P);
    chk("nom_align_k",     {28'b0, txcharisk_out}, 32'd1);
    chk("nom_align_noidl", {31'b0, txelecidle}, 32'd0);
    rx_word(ALIGN_P, 4'b0001);
    step();
    chk("nom_sync_tx", txdata_out, SYNC_P);
    step(3);
    rx_word(SYNC_P, 4'b0001);
    step(2);
    chk("nom_no_early_up", {31'b0, link_up}, 32'd0);
    step();
    chk("nom_link_up",   {31'b0, link_up},   32'd1);
    chk("nom_phy_ready", {31'b0, phy_ready}, 32'd1);
    step();
    chk("nom_link_up_once", {31'b0, link_up}, 32'd0);

    // LINK data path and rx bypass
    txdata_in = 32'h12345678; txcharisk_in = 4'b0000;
    rx_word(32'hCAFEF00D, 4'b1010);
    #1;
    chk("rx_bypass_data", rxdata_out, 32'hCAFEF00D);
    chk("rx_bypass_k",    {28'b0, rxcharisk_out}, 32'h0000000A);
    step();
    chk("link_txdata", txdata_out, 32'h12345678);
    chk("link_txk",    {28'b0, txcharisk_out}, 32'd0);
    rxcominitdet_in = 1'b1; step();
    chk("link_down_pulse", {31'b0, link_down}, 32'd1);
    chk("link_recominit",  {31'b0, txcominit}, 32'd1);
    chk("link_drop_ready", {31'b0, phy_ready}, 32'd0);
    rxcominitdet_in = 1'b0;
    rx_word(D102, 4'b0000);
    step();
    chk("link_down_once", {31'b0, link_down}, 32'd0);

    // No COMWAKE: timeout exactly 32768 cycles after entering WAIT_COMWAKE
    txcomfinish_in = 1'b1; step();
    txcomfinish_in = 1'b0;
    early = 0;
    for (int i = 1; i < 32768; i++) begin
      step();
      if (oob_error !== 1'b0) early++;
    end
    chk("cw_no_early_err", early, 0);
    step();
    chk("cw_timeout_err",  {31'b0, oob_error}, 32'd1);
    chk("cw_timeout_idle", {31'b0, txelecidle}, 32'd1);
    step();
    chk("cw_err_once", {31'b0, oob_error}, 32'd0);

    // No host ALIGNp: D10.2 only
    go_to_align();
    early = 0;
    for (int i = 1; i < 4096; i++) begin
      step();
      if (oob_error !== 1'b0 || phy_ready !== 1'b0 || txelecidle !== 1'b0) early++;
    end
    chk("al_no_early_err", early, 0);
    step();
    chk("al_timeout_err",  {31'b0, oob_error}, 32'd1);
    chk("al_timeout_idle", {31'b0, txelecidle}, 32'd1);
    chk("al_no_ready",     {31'b0, phy_ready}, 32'd0);

    // SYNC counting: SYNCp,SYNCp,ALIGNp,SYNCp x3
    go_to_align();
    rx_word(ALIGN_P, 4'b0001); step();
    sync_seq = '{SYNC_P, SYNC_P, ALIGN_P, SYNC_P, SYNC_P, SYNC_P};
    sync_k   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      rx_word(sync_seq[i], sync_k[i]);
      step();
      chk($sformatf("sync_word%0d_up", i + 1), {31'b0, link_up}, (i == 5) ? 32'd1 : 32'd0);
    end

    // gtx_ready loss in LINK
    rx_word(D102, 4'b0000);
    gtx_ready = 1'b0; step();
    chk("gtx_drop_down", {31'b0, link_down}, 32'd1);
    chk("gtx_drop_noerr", {31'b0, oob_error}, 32'd0);
    chk("gtx_drop_idle", {31'b0, txelecidle}, 32'd1);
    gtx_ready = 1'b1; step();

    // ALIGNp arriving in the timeout cycle wins over the timeout
    go_to_align();
    step(4095);
    rx_word(ALIGN_P, 4'b0001); step();
    chk("race_no_err", {31'b0, oob_error}, 32'd0);
    chk("race_sync",   txdata_out, SYNC_P);
    rx_word(D102, 4'b0000);
    rst = 1'b1; step();
    rst = 1'b0; step(3);

    // rst in SEND_ALIGN
    go_to_align();
    step(2);
    chk("pre_rst_align", txdata_out, ALIGN_P);
    rst = 1'b1; step();
    chk("rst_mid_idle",   {31'b0, txelecidle}, 32'd1);
    chk("rst_mid_txdata", txdata_out, 32'd0);
    chk("rst_mid_flags",  {30'b0, oob_error, link_down}, 32'd0);
    rst = 1'b0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
